// File: rtl/bus_ctrl_if.sv
// Host-side handshake bundle for the peripheral bus controller.
// The host bridge drives the request half and sees completion and status.
// The controller sits on the slave side of this bundle.
interface bus_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  err;
    logic                  busy;

    modport master (
        output req,
        output we,
        output address,
        output wdata,
        input  rdata,
        input  ready,
        input  err,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  address,
        input  wdata,
        output rdata,
        output ready,
        output err,
        output busy
    );

endinterface

// File: rtl/bus_ctrl.sv
// Host-side bus transaction controller for the FPGA peripheral bus.
// It accepts one request at a time and decodes the upper address field to a slot.
// The selected slot gets a registered, glitch-free active-low chip select.
// The controller waits for that slot's ack, bounded by a timeout, then reports
// read data and status with a single-cycle ready pulse.
// Requests that arrive while a transaction is in flight are dropped, not queued.
module bus_ctrl #(
    parameter int NUMBER_OF_DEVICE  = 4,
    parameter int DEVICE_ADDR_WIDTH = 14,
    parameter int BUS_ADDR_WIDTH    = 2,
    parameter int DATA_WIDTH        = 16,
    parameter int TIMEOUT           = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    bus_ctrl_if.slave                              host,
    output logic [NUMBER_OF_DEVICE-1:0]            cso,
    output logic [DEVICE_ADDR_WIDTH-1:0]           dev_addr,
    output logic                                   dev_we,
    output logic [DATA_WIDTH-1:0]                  dev_wdata,
    input  logic [NUMBER_OF_DEVICE*DATA_WIDTH-1:0] dev_rdata,
    input  logic [NUMBER_OF_DEVICE-1:0]            dev_ack
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [BUS_ADDR_WIDTH-1:0]     sel_q, sel_d;
    logic [DEVICE_ADDR_WIDTH-1:0]  dev_addr_q, dev_addr_d;
    logic                          dev_we_q, dev_we_d;
    logic [DATA_WIDTH-1:0]         dev_wdata_q, dev_wdata_d;
    logic [DATA_WIDTH-1:0]         rdata_q, rdata_d;
    logic                          err_q, err_d;
    logic                          ready_q, ready_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [NUMBER_OF_DEVICE-1:0]   cso_q, cso_d;

    logic [BUS_ADDR_WIDTH-1:0]     req_sel;
    logic                          req_sel_valid;
    logic                          ack_sel;
    logic [DATA_WIDTH-1:0]         rdata_sel;

    assign req_sel       = host.address[DEVICE_ADDR_WIDTH +: BUS_ADDR_WIDTH];
    assign req_sel_valid = int'(req_sel) < NUMBER_OF_DEVICE;

    // Pick out the latched slot's ack and read word, ignoring every other slot.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUMBER_OF_DEVICE; i++) begin
            if (int'(sel_q) == i) begin
                ack_sel   = dev_ack[i];
                rdata_sel = dev_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transaction sequencing: latch the request, wait for ack or timeout, then report.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        dev_addr_d  = dev_addr_q;
        dev_we_d    = dev_we_q;
        dev_wdata_d = dev_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (host.req) begin
                    sel_d       = req_sel;
                    dev_addr_d  = host.address[DEVICE_ADDR_WIDTH-1:0];
                    dev_we_d    = host.we;
                    dev_wdata_d = host.wdata;
                    err_d       = 1'b0;
                    if (req_sel_valid) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (ack_sel) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!dev_we_q) begin
                        rdata_d = rdata_sel;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Chip select and ready are precomputed from the next state so they come straight off flops.
    always_comb begin
        cso_d   = '1;
        ready_d = (state_d == ST_DONE);
        if (state_d == ST_ACCESS) begin
            for (int i = 0; i < NUMBER_OF_DEVICE; i++) begin
                if (int'(sel_d) == i) begin
                    cso_d[i] = 1'b0;
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            dev_addr_q  <= '0;
            dev_we_q    <= 1'b0;
            dev_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            cso_q       <= '1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            dev_addr_q  <= dev_addr_d;
            dev_we_q    <= dev_we_d;
            dev_wdata_q <= dev_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            cso_q       <= cso_d;
        end
    end

    assign host.rdata = rdata_q;
    assign host.ready = ready_q;
    assign host.err   = err_q;
    assign host.busy  = (state_q != ST_IDLE);
    assign cso        = cso_q;
    assign dev_addr   = dev_addr_q;
    assign dev_we     = dev_we_q;
    assign dev_wdata  = dev_wdata_q;

    // Never select more than one slot, and only pulse ready while the bus is still held.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert ($onehot0(~cso_q));
            assert (!ready_q || (state_q == ST_DONE));
        end
    end

endmodule
